// File: rtl/pipe_hazard_sched.sv
// pipe_hazard_sched: central stall/flush scheduler for the 5-stage pipeline.
// Resolves load-use and ID-branch operand hazards, freezes the whole pipe
// while a data-memory access is outstanding, and kills the IF/ID slot on a
// taken branch or jump. Enables/flushes are combinational so the pipe reacts
// in the same cycle the hazard appears; only the wait FSM and the counters
// are registered.
module pipe_hazard_sched #(
    parameter int unsigned CNT_W   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [4:0]       id_rs_i,
    input  logic [4:0]       id_rt_i,
    input  logic             id_uses_rt_i,
    input  logic             id_branch_i,
    input  logic             id_jump_i,
    input  logic             br_taken_i,
    input  logic [4:0]       ex_rd_i,
    input  logic             ex_regwrite_i,
    input  logic             ex_memread_i,
    input  logic [4:0]       mem_rd_i,
    input  logic             mem_memread_i,
    input  logic             dmem_req_i,
    input  logic             dmem_ready_i,
    output logic             pc_we_o,
    output logic             ifid_we_o,
    output logic             ifid_flush_o,
    output logic             idex_flush_o,
    output logic             pipe_we_o,
    output logic             loaduse_hd_o,
    output logic             branch_hd_o,
    output logic             mem_timeout_o,
    output logic [CNT_W-1:0] stall_cnt_o
);

    localparam int unsigned REG_W  = 5;
    localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic {
        RUN  = 1'b0,
        MEMW = 1'b1
    } state_e;

    state_e state_q, state_d;

    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              timeout_q,  timeout_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    // Combinational hazard terms
    logic ex_match_c;
    logic mem_match_c;
    logic lu_c;
    logic bh_c;
    logic redir_c;
    logic freeze_c;

    // Combinational control outputs (before port assignment)
    logic pc_we_c;
    logic ifid_we_c;
    logic ifid_flush_c;
    logic idex_flush_c;
    logic pipe_we_c;
    logic loaduse_hd_c;
    logic branch_hd_c;

    // A producer register matches the ID instruction's sources; $zero never matches.
    function automatic logic src_match(
        input logic [REG_W-1:0] r,
        input logic [REG_W-1:0] rs,
        input logic [REG_W-1:0] rt,
        input logic             uses_rt
    );
        src_match = (r != REG_W'(0)) && ((r == rs) || (uses_rt && (r == rt)));
    endfunction

    // Hazard detection and memory-wait freeze condition
    always_comb begin
        ex_match_c  = src_match(ex_rd_i,  id_rs_i, id_rt_i, id_uses_rt_i);
        mem_match_c = src_match(mem_rd_i, id_rs_i, id_rt_i, id_uses_rt_i);
        lu_c        = ex_memread_i & ex_match_c;
        bh_c        = id_branch_i & ((ex_regwrite_i & ex_match_c) |
                                     (mem_memread_i & mem_match_c));
        redir_c     = id_jump_i | (id_branch_i & br_taken_i & ~bh_c);
        freeze_c    = ~dmem_ready_i &
                      ((state_q == MEMW) | ((state_q == RUN) & dmem_req_i));
    end

    // Memory-wait FSM: state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Memory-wait FSM: next state (a request completing in-cycle stays in RUN)
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            RUN:     if (dmem_req_i && !dmem_ready_i) state_d = MEMW;
            MEMW:    if (dmem_ready_i)                state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    // Pipeline control, priority: reset > freeze > hazard > redirect > run
    always_comb begin
        pc_we_c      = 1'b1;
        ifid_we_c    = 1'b1;
        pipe_we_c    = 1'b1;
        ifid_flush_c = 1'b0;
        idex_flush_c = 1'b0;
        loaduse_hd_c = 1'b0;
        branch_hd_c  = 1'b0;
        if (!rst_n) begin
            pc_we_c      = 1'b0;
            ifid_we_c    = 1'b0;
            pipe_we_c    = 1'b0;
            ifid_flush_c = 1'b1;
            idex_flush_c = 1'b1;
        end else if (freeze_c) begin
            pc_we_c      = 1'b0;
            ifid_we_c    = 1'b0;
            pipe_we_c    = 1'b0;
        end else if (lu_c || bh_c) begin
            pc_we_c      = 1'b0;
            ifid_we_c    = 1'b0;
            idex_flush_c = 1'b1;
            loaduse_hd_c = lu_c;
            branch_hd_c  = bh_c;
        end else if (redir_c) begin
            ifid_flush_c = 1'b1;
        end
    end

    // Wait-length tracking and sticky timeout flag
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        timeout_d  = timeout_q;
        if (state_q == MEMW) begin
            if (dmem_ready_i) begin
                wait_cnt_d = '0;
            end else if (wait_cnt_q != WAIT_W'(TIMEOUT)) begin
                wait_cnt_d = wait_cnt_q + WAIT_W'(1);
            end
        end
        if (wait_cnt_d == WAIT_W'(TIMEOUT)) begin
            timeout_d = 1'b1;
        end
    end

    // Saturating count of cycles in which the PC did not advance
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_we_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    // Counter and flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_cnt_q  <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            wait_cnt_q  <= wait_cnt_d;
            timeout_q   <= timeout_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign pc_we_o       = pc_we_c;
    assign ifid_we_o     = ifid_we_c;
    assign ifid_flush_o  = ifid_flush_c;
    assign idex_flush_o  = idex_flush_c;
    assign pipe_we_o     = pipe_we_c;
    assign loaduse_hd_o  = loaduse_hd_c;
    assign branch_hd_o   = branch_hd_c;
    assign mem_timeout_o = timeout_q;
    assign stall_cnt_o   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_sched.sv
// Bench for pipe_hazard_sched: directed vectors, a per-cycle reference model
// checked at every falling edge, and literal expectations at key points.
module tb_pipe_hazard_sched;

    localparam int unsigned CNT_W   = 4;
    localparam int unsigned TIMEOUT = 4;
    localparam int          CNT_MAX = 15;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [4:0]       id_rs, id_rt, ex_rd, mem_rd;
    logic             id_uses_rt, id_branch, id_jump, br_taken;
    logic             ex_regwrite, ex_memread, mem_memread, dmem_req, dmem_ready;
    logic             pc_we, ifid_we, ifid_flush, idex_flush, pipe_we;
    logic             loaduse_hd, branch_hd, mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    bit m_wait;
    int m_wcnt;
    bit m_tmo;
    int m_scnt;

    pipe_hazard_sched #(.CNT_W(CNT_W), .TIMEOUT(TIMEOUT)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .id_rs_i       (id_rs),
        .id_rt_i       (id_rt),
        .id_uses_rt_i  (id_uses_rt),
        .id_branch_i   (id_branch),
        .id_jump_i     (id_jump),
        .br_taken_i    (br_taken),
        .ex_rd_i       (ex_rd),
        .ex_regwrite_i (ex_regwrite),
        .ex_memread_i  (ex_memread),
        .mem_rd_i      (mem_rd),
        .mem_memread_i (mem_memread),
        .dmem_req_i    (dmem_req),
        .dmem_ready_i  (dmem_ready),
        .pc_we_o       (pc_we),
        .ifid_we_o     (ifid_we),
        .ifid_flush_o  (ifid_flush),
        .idex_flush_o  (idex_flush),
        .pipe_we_o     (pipe_we),
        .loaduse_hd_o  (loaduse_hd),
        .branch_hd_o   (branch_hd),
        .mem_timeout_o (mem_timeout),
        .stall_cnt_o   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic bit mx(input logic [4:0] r);
        return (r != 0) && (r == id_rs || (id_uses_rt && r == id_rt));
    endfunction

    // Model: evaluate the rules on the current inputs, compare, then advance
    always @(negedge clk) begin
        bit lu, bh, redir, frz;
        bit e_pc, e_ifwe, e_pipe, e_iff, e_idf, e_lu, e_bh;
        if (!rst_n) begin
            chk("rst_pc_we", 32'(pc_we), 0);
            chk("rst_ifid_we", 32'(ifid_we), 0);
            chk("rst_pipe_we", 32'(pipe_we), 0);
            chk("rst_ifid_flush", 32'(ifid_flush), 1);
            chk("rst_idex_flush", 32'(idex_flush), 1);
            chk("rst_hd", 32'({loaduse_hd, branch_hd}), 0);
            chk("rst_timeout", 32'(mem_timeout), 0);
            chk("rst_stall_cnt", 32'(stall_cnt), 0);
            m_wait = 0; m_wcnt = 0; m_tmo = 0; m_scnt = 0;
        end else begin
            lu    = ex_memread && mx(ex_rd);
            bh    = id_branch && ((ex_regwrite && mx(ex_rd)) || (mem_memread && mx(mem_rd)));
            redir = id_jump || (id_branch && br_taken && !bh);
            frz   = !dmem_ready && (m_wait || dmem_req);
            e_pc = 1; e_ifwe = 1; e_pipe = 1; e_iff = 0; e_idf = 0; e_lu = 0; e_bh = 0;
            if (frz) begin
                e_pc = 0; e_ifwe = 0; e_pipe = 0;
            end else if (lu || bh) begin
                e_pc = 0; e_ifwe = 0; e_idf = 1; e_lu = lu; e_bh = bh;
            end else if (redir) begin
                e_iff = 1;
            end
            chk("m_pc_we", 32'(pc_we), 32'(e_pc));
            chk("m_ifid_we", 32'(ifid_we), 32'(e_ifwe));
            chk("m_pipe_we", 32'(pipe_we), 32'(e_pipe));
            chk("m_ifid_flush", 32'(ifid_flush), 32'(e_iff));
            chk("m_idex_flush", 32'(idex_flush), 32'(e_idf));
            chk("m_loaduse_hd", 32'(loaduse_hd), 32'(e_lu));
            chk("m_branch_hd", 32'(branch_hd), 32'(e_bh));
            chk("m_timeout", 32'(mem_timeout), 32'(m_tmo));
            chk("m_stall_cnt", 32'(stall_cnt), 32'(m_scnt));
            if (!e_pc && m_scnt < CNT_MAX) m_scnt++;
            if (m_wait && dmem_ready) m_wcnt = 0;
            else if (m_wait) m_wcnt++;
            if (m_wcnt >= TIMEOUT) m_tmo = 1;
            m_wait = frz;
        end
    end

    task automatic clear_in();
        id_rs = 0; id_rt = 0; ex_rd = 0; mem_rd = 0;
        id_uses_rt = 0; id_branch = 0; id_jump = 0; br_taken = 0;
        ex_regwrite = 0; ex_memread = 0; mem_memread = 0;
        dmem_req = 0; dmem_ready = 0;
    endtask

    // Advance to just after the next rising edge, where inputs are driven
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_in();
        cyc(); cyc();
        #2;
        chk("L_rst_pc_we", 32'(pc_we), 0);
        chk("L_rst_ifid_flush", 32'(ifid_flush), 1);

        // Reset release, idle
        cyc(); rst_n = 1'b1; #2;
        chk("L_idle_pc_we", 32'(pc_we), 1);
        chk("L_idle_pipe_we", 32'(pipe_we), 1);
        chk("L_idle_flush", 32'({ifid_flush, idex_flush}), 0);
        chk("L_idle_stall_cnt", 32'(stall_cnt), 0);

        // Load-use
        cyc(); ex_memread = 1; ex_rd = 5; id_rs = 5; #2;
        chk("L_lu_hd", 32'(loaduse_hd), 1);
        chk("L_lu_pc_we", 32'(pc_we), 0);
        chk("L_lu_idex_flush", 32'(idex_flush), 1);
        cyc(); clear_in(); #2;
        chk("L_lu_done_hd", 32'(loaduse_hd), 0);
        chk("L_lu_stall_cnt", 32'(stall_cnt), 1);

        // $zero producer never stalls
        cyc(); ex_memread = 1; ex_rd = 0; id_rs = 0; #2;
        chk("L_r0_pc_we", 32'(pc_we), 1);
        chk("L_r0_hd", 32'(loaduse_hd), 0);

        // Branch operand hazard, then resolved taken branch
        cyc(); clear_in();
        id_branch = 1; mem_memread = 1; mem_rd = 8; id_rt = 8; id_uses_rt = 1; br_taken = 1; #2;
        chk("L_bh_hd", 32'(branch_hd), 1);
        chk("L_bh_ifid_flush", 32'(ifid_flush), 0);
        cyc(); mem_memread = 0; #2;
        chk("L_br_ifid_flush", 32'(ifid_flush), 1);
        chk("L_br_pc_we", 32'(pc_we), 1);
        cyc(); clear_in(); #2;
        chk("L_br_once", 32'(ifid_flush), 0);

        // Jump
        cyc(); id_jump = 1; #2;
        chk("L_jmp_flush", 32'(ifid_flush), 1);

        // Memory wait 3 cycles with a load-use pending underneath
        cyc(); clear_in(); dmem_req = 1; ex_memread = 1; ex_rd = 3; id_rs = 3;
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("L_mw_pipe_we", 32'(pipe_we), 0);
            chk("L_mw_lu_masked", 32'({loaduse_hd, idex_flush, ifid_flush}), 0);
            cyc();
        end
        ex_memread = 0; dmem_ready = 1; #2;
        chk("L_mw_release", 32'(pipe_we), 1);
        chk("L_mw_stall_cnt", 32'(stall_cnt), 5);

        // Request completing in the same cycle does not freeze
        cyc(); dmem_req = 1; dmem_ready = 1; #2;
        chk("L_hit_pipe_we", 32'(pipe_we), 1);

        // Timeout: 6 waiting cycles
        cyc(); dmem_ready = 0;
        repeat (5) cyc();
        cyc(); dmem_req = 0; dmem_ready = 1; #2;
        chk("L_tmo_set", 32'(mem_timeout), 1);
        cyc(); dmem_ready = 0; #2;
        chk("L_tmo_sticky", 32'(mem_timeout), 1);
        chk("L_tmo_stall_cnt", 32'(stall_cnt), 11);

        // Reset in the middle of a wait
        cyc(); dmem_req = 1;
        cyc(); cyc(); rst_n = 1'b0; #2;
        chk("L_rst_mid_tmo", 32'(mem_timeout), 0);
        chk("L_rst_mid_pc_we", 32'(pc_we), 0);
        cyc(); dmem_req = 0;
        cyc(); rst_n = 1'b1; #2;
        chk("L_post_rst_pipe_we", 32'(pipe_we), 1);
        chk("L_post_rst_cnt", 32'(stall_cnt), 0);

        // Saturation: 20 load-use stall cycles
        cyc(); ex_memread = 1; ex_rd = 7; id_rs = 7;
        repeat (20) cyc();
        clear_in(); #2;
        chk("L_sat_cnt", 32'(stall_cnt), 15);
        cyc(); #2;
        chk("L_sat_hold", 32'(stall_cnt), 15);

        // Combination sweep of hazard/redirect inputs
        for (int i = 0; i < 128; i++) begin
            cyc();
            id_rs = 1; id_rt = 2;
            ex_memread  = i[0]; ex_regwrite = i[1]; mem_memread = i[2];
            id_branch   = i[3]; br_taken    = i[4]; id_jump     = i[5];
            id_uses_rt  = i[6];
            ex_rd  = 5'((i % 3 == 0) ? 1 : ((i % 3 == 1) ? 2 : 0));
            mem_rd = 5'(((i / 3) % 3 == 0) ? 2 : (((i / 3) % 3 == 1) ? 1 : 9));
        end
        cyc(); clear_in();
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
